// File: rtl/dram_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port byte RAM among NCORES cores.
// Optional read broadcast of same-address pure reads: define DRAM_ARB_MERGE_EN.
module dram_arbiter #(
    parameter int NCORES = 4,
    parameter int AW     = 8,
    parameter int DW     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCORES-1:0]    req_rd,
    input  logic [NCORES-1:0]    req_wr,
    input  logic [NCORES*AW-1:0] req_addr,
    input  logic [NCORES*DW-1:0] req_wdata,
    input  logic [DW-1:0]        ram_q,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_din,
    output logic                 ram_wren,
    output logic [NCORES-1:0]    gnt,
    output logic [NCORES-1:0]    done,
    output logic [NCORES*DW-1:0] rdata
);

    localparam int IW = $clog2(NCORES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RDWAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [IW-1:0]     last;
    logic [NCORES-1:0] pending;
    logic [IW-1:0]     win;
    logic              found;
    logic [NCORES-1:0] sel;
    logic [IW-1:0]     hi;

    assign pending = req_rd | req_wr;

    // Search starts just after the most recently served core.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= NCORES; k++) begin
            if (!found && pending[IW'((int'(last) + k) % NCORES)]) begin
                found = 1'b1;
                win   = IW'((int'(last) + k) % NCORES);
            end
        end
    end

`ifdef DRAM_ARB_MERGE_EN
    // Pure reads of the winner's address ride along on the same RAM access.
    always_comb begin
        sel      = '0;
        sel[win] = 1'b1;
        if (req_rd[win] && !req_wr[win]) begin
            for (int i = 0; i < NCORES; i++) begin
                if (req_rd[i] && !req_wr[i] &&
                    req_addr[i*AW +: AW] == req_addr[win*AW +: AW])
                    sel[i] = 1'b1;
            end
        end
    end
`else
    always_comb begin
        sel      = '0;
        sel[win] = 1'b1;
    end
`endif

    always_comb begin
        hi = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (gnt[i])
                hi = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            last     <= IW'(NCORES - 1);
            gnt      <= '0;
            done     <= '0;
            rdata    <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_wren <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= '0;
                    if (found) begin
                        gnt      <= sel;
                        ram_addr <= req_addr[win*AW +: AW];
                        ram_din  <= req_wdata[win*DW +: DW];
                        ram_wren <= req_wr[win];
                        state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    ram_wren <= 1'b0;
                    if (ram_wren) begin
                        done  <= gnt;
                        state <= S_DONE;
                    end else begin
                        state <= S_RDWAIT;
                    end
                end
                S_RDWAIT: begin
                    for (int i = 0; i < NCORES; i++) begin
                        if (gnt[i])
                            rdata[i*DW +: DW] <= ram_q;
                    end
                    done  <= gnt;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= '0;
                    last  <= hi;
                    gnt   <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter with a behavioural one-cycle-latency RAM.
// Expected completions are queued at drive time and popped on each done pulse.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_rd = '0;
    logic [3:0]  req_wr = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [7:0]  ram_q;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_din;
    logic        ram_wren;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [31:0] rdata;

    dram_arbiter #(.NCORES(4), .AW(8), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .ram_q(ram_q), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_wren(ram_wren), .gnt(gnt), .done(done), .rdata(rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_din;
        ram_q <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] mask;
        int         due;
        bit         rd;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   wren_cnt = 0;
    int   wren_cyc = 0;
    logic [7:0] wren_addr = '0;
    logic [7:0] wren_din = '0;
    bit   auto_drop = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    // Output monitor, one cycle-accurate sample just after each edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (ram_wren) begin
            wren_cnt++;
            wren_cyc  = cyc;
            wren_addr = ram_addr;
            wren_din  = ram_din;
        end
        if (done != 4'b0) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {28'b0, done}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_mask", {28'b0, done}, {28'b0, e.mask});
                chk("done_cyc", cyc, e.due);
                if (e.rd)
                    for (int i = 0; i < 4; i++)
                        if (e.mask[i])
                            chk("rdata", {24'b0, rdata[i*8 +: 8]},
                                {24'b0, e.data});
            end
        end
    end

    task automatic set_req(input int c, input bit rd, input bit wr,
                           input logic [7:0] a, input logic [7:0] d);
        req_rd[c]          = rd;
        req_wr[c]          = wr;
        req_addr[c*8 +: 8] = a;
        req_wdata[c*8 +: 8] = d;
    endtask

    task automatic expect_done(input logic [3:0] m, input int lat,
                               input bit rd, input logic [7:0] d);
        exp_t e;
        e.mask = m;
        e.due  = cyc + lat;
        e.rd   = rd;
        e.data = d;
        sb.push_back(e);
    endtask

    // Runs until every queued completion is seen; lands in the next IDLE cycle.
    task automatic wait_sb(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (auto_drop) begin
                req_rd = req_rd & ~done;
                req_wr = req_wr & ~done;
            end
        end
        if (sb.size() != 0) begin
            chk("timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        req_rd = '0;
        req_wr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    int k;

    initial begin
        do_reset();
        chk("rst_gnt", {28'b0, gnt}, 0);
        chk("rst_done", {28'b0, done}, 0);
        chk("rst_wren", {31'b0, ram_wren}, 0);
        chk("rst_addr", {24'b0, ram_addr}, 0);
        chk("rst_din", {24'b0, ram_din}, 0);
        chk("rst_rdata", rdata, 0);

        // single write, then read back
        k = cyc;
        wren_cnt = 0;
        set_req(0, 1'b0, 1'b1, 8'h10, 8'h5A);
        expect_done(4'b0001, 2, 1'b0, 8'h00);
        wait_sb(20);
        chk("wr_wren_cnt", wren_cnt, 1);
        chk("wr_wren_cyc", wren_cyc, k + 1);
        chk("wr_addr", {24'b0, wren_addr}, 32'h10);
        chk("wr_din", {24'b0, wren_din}, 32'h5A);

        set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        expect_done(4'b0001, 3, 1'b1, 8'h5A);
        wait_sb(20);
        repeat (3) @(negedge clk);
        chk("rdata0_hold", {24'b0, rdata[7:0]}, 32'h5A);

        // continuous writes from all cores
        do_reset();
        auto_drop = 1'b0;
        for (int i = 0; i < 4; i++)
            set_req(i, 1'b0, 1'b1, 8'(8'h40 + i), 8'(8'hA0 + i));
        expect_done(4'b0001, 2, 1'b0, 8'h00);
        expect_done(4'b0010, 5, 1'b0, 8'h00);
        expect_done(4'b0100, 8, 1'b0, 8'h00);
        expect_done(4'b1000, 11, 1'b0, 8'h00);
        expect_done(4'b0001, 14, 1'b0, 8'h00);
        wait_sb(40);
        req_wr = '0;
        auto_drop = 1'b1;
        repeat (4) @(negedge clk);

        // same-address reads from cores 1 and 2
        set_req(0, 1'b0, 1'b1, 8'h22, 8'h3C);
        expect_done(4'b0001, 2, 1'b0, 8'h00);
        wait_sb(20);
        set_req(1, 1'b1, 1'b0, 8'h22, 8'h00);
        set_req(2, 1'b1, 1'b0, 8'h22, 8'h00);
`ifdef DRAM_ARB_MERGE_EN
        expect_done(4'b0110, 3, 1'b1, 8'h3C);
`else
        expect_done(4'b0010, 3, 1'b1, 8'h3C);
        expect_done(4'b0100, 7, 1'b1, 8'h3C);
`endif
        wait_sb(30);

        // read+write on one core is a write only
        set_req(2, 1'b1, 1'b1, 8'h30, 8'h77);
        expect_done(4'b0100, 2, 1'b0, 8'h00);
        wait_sb(20);
        chk("rw_lane2_kept", {24'b0, rdata[23:16]}, 32'h3C);
        set_req(0, 1'b1, 1'b0, 8'h30, 8'h00);
        expect_done(4'b0001, 3, 1'b1, 8'h77);
        wait_sb(20);

        // reset during a write access
        set_req(3, 1'b0, 1'b1, 8'h50, 8'h99);
        @(negedge clk);
        chk("pre_rst_wren", {31'b0, ram_wren}, 1);
        rst_n = 1'b0;
        req_wr = '0;
        #1;
        chk("mid_rst_gnt", {28'b0, gnt}, 0);
        chk("mid_rst_wren", {31'b0, ram_wren}, 0);
        chk("mid_rst_addr", {24'b0, ram_addr}, 0);
        chk("mid_rst_din", {24'b0, ram_din}, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_done", {28'b0, done}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("dropped_write", {24'b0, mem[8'h50]}, 0);
        set_req(3, 1'b0, 1'b1, 8'h51, 8'h11);
        set_req(0, 1'b0, 1'b1, 8'h52, 8'h22);
        expect_done(4'b0001, 2, 1'b0, 8'h00);
        expect_done(4'b1000, 5, 1'b0, 8'h00);
        wait_sb(30);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
